// File: rtl/rs_age_ordered_if.sv
// rtl/rs_age_ordered_if.sv - dispatch/wakeup/issue bundle for the age-ordered reservation station
interface rs_age_ordered_if #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 3,
    parameter int PAYLOAD_W  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                                  flush;
    logic [DISPATCH_W-1:0]                 disp_valid;
    logic [DISPATCH_W-1:0][PREG_W-1:0]     disp_rs1;
    logic [DISPATCH_W-1:0][PREG_W-1:0]     disp_rs2;
    logic [DISPATCH_W-1:0]                 disp_rs1_rdy;
    logic [DISPATCH_W-1:0]                 disp_rs2_rdy;
    logic [DISPATCH_W-1:0][ROB_W-1:0]      disp_rob;
    logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]  disp_payload;
    logic                                  disp_ready;
    logic [CDB_W-1:0]                      cdb_valid;
    logic [CDB_W-1:0][PREG_W-1:0]          cdb_tag;
    logic [ISSUE_W-1:0]                    iss_valid;
    logic [ISSUE_W-1:0]                    iss_ready;
    logic [ISSUE_W-1:0][PREG_W-1:0]        iss_rs1;
    logic [ISSUE_W-1:0][PREG_W-1:0]        iss_rs2;
    logic [ISSUE_W-1:0][ROB_W-1:0]         iss_rob;
    logic [ISSUE_W-1:0][PAYLOAD_W-1:0]     iss_payload;
    logic [CW-1:0]                         count;
    logic                                  full;

    modport master (
        output flush, disp_valid, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
               disp_rob, disp_payload, cdb_valid, cdb_tag, iss_ready,
        input  disp_ready, iss_valid, iss_rs1, iss_rs2, iss_rob, iss_payload, count, full
    );

    modport slave (
        input  flush, disp_valid, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
               disp_rob, disp_payload, cdb_valid, cdb_tag, iss_ready,
        output disp_ready, iss_valid, iss_rs1, iss_rs2, iss_rob, iss_payload, count, full
    );
endinterface

// File: rtl/rs_age_ordered.sv
// rtl/rs_age_ordered.sv - reservation station with CDB wakeup, oldest-first multi-port issue
module rs_age_ordered #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 3,
    parameter int PAYLOAD_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    rs_age_ordered_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     r_valid, r_rdy1, r_rdy2;
    logic [PREG_W-1:0]    r_rs1 [DEPTH];
    logic [PREG_W-1:0]    r_rs2 [DEPTH];
    logic [ROB_W-1:0]     r_rob [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [DEPTH-1:0]     r_older [DEPTH];
    logic [CW-1:0]        r_count;

    logic [DEPTH-1:0]      w_elig, w_taken, w_wake1, w_wake2, w_alloc, w_issue_free;
    logic [DEPTH-1:0]      w_older_next [DEPTH];
    logic [DISPATCH_W-1:0] w_drdy1, w_drdy2;
    logic [ISSUE_W-1:0]    w_sel_vld;
    logic [IW-1:0]         w_sel_idx [ISSUE_W];
    int                    w_slot [DEPTH];
    int                    w_n_alloc, w_n_iss;
    logic [CW-1:0]         w_count_next;
    logic                  w_full;

    assign w_full         = (r_count > CW'(DEPTH - DISPATCH_W));
    assign bus.full       = w_full;
    assign bus.disp_ready = ~w_full;
    assign bus.count      = r_count;
    assign w_elig         = r_valid & r_rdy1 & r_rdy2;

    // Wakeup for resident entries, plus bypass of same-cycle broadcasts into dispatched operands
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = 1'b0;
            w_wake2[i] = 1'b0;
            for (int c = 0; c < CDB_W; c++) begin
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == r_rs1[i]) w_wake1[i] = 1'b1;
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == r_rs2[i]) w_wake2[i] = 1'b1;
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            w_drdy1[k] = bus.disp_rs1_rdy[k] || (bus.disp_rs1[k] == '0);
            w_drdy2[k] = bus.disp_rs2_rdy[k] || (bus.disp_rs2[k] == '0);
            for (int c = 0; c < CDB_W; c++) begin
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.disp_rs1[k]) w_drdy1[k] = 1'b1;
                if (bus.cdb_valid[c] && bus.cdb_tag[c] == bus.disp_rs2[k]) w_drdy2[k] = 1'b1;
            end
        end
    end

    // Oldest-first select: an entry wins when it is older than every other remaining candidate
    always_comb begin : select_p
        logic l_oldest;
        w_taken = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_sel_vld[p] = 1'b0;
            w_sel_idx[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                l_oldest = w_elig[i] && !w_taken[i];
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != i && w_elig[j] && !w_taken[j] && !r_older[i][j]) l_oldest = 1'b0;
                end
                if (l_oldest) begin
                    w_sel_vld[p] = 1'b1;
                    w_sel_idx[p] = IW'(i);
                end
            end
            if (w_sel_vld[p]) w_taken[w_sel_idx[p]] = 1'b1;
        end
    end

    always_comb begin
        w_issue_free = '0;
        w_n_iss      = 0;
        for (int p = 0; p < ISSUE_W; p++) begin
            bus.iss_valid[p]   = w_sel_vld[p];
            bus.iss_rs1[p]     = r_rs1[w_sel_idx[p]];
            bus.iss_rs2[p]     = r_rs2[w_sel_idx[p]];
            bus.iss_rob[p]     = r_rob[w_sel_idx[p]];
            bus.iss_payload[p] = r_payload[w_sel_idx[p]];
            if (w_sel_vld[p] && bus.iss_ready[p]) begin
                w_issue_free[w_sel_idx[p]] = 1'b1;
                w_n_iss = w_n_iss + 1;
            end
        end
    end

    // Slot k lands in the k-th free entry; the full threshold guarantees enough free entries
    always_comb begin : alloc_p
        int n;
        n         = 0;
        w_n_alloc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_alloc[i] = 1'b0;
            w_slot[i]  = 0;
            if (!r_valid[i] && n < DISPATCH_W) begin
                if (bus.disp_valid[n] && !w_full) begin
                    w_alloc[i] = 1'b1;
                    w_slot[i]  = n;
                    w_n_alloc  = w_n_alloc + 1;
                end
                n = n + 1;
            end
        end
        w_count_next = r_count + CW'(w_n_alloc) - CW'(w_n_iss);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (w_alloc[j])
                    w_older_next[i][j] = r_valid[i] || (w_alloc[i] && w_slot[i] < w_slot[j]);
                else if (w_alloc[i])
                    w_older_next[i][j] = 1'b0;
                else
                    w_older_next[i][j] = r_older[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (bus.flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc[i]) begin
                    r_valid[i]   <= 1'b1;
                    r_rs1[i]     <= bus.disp_rs1[w_slot[i]];
                    r_rs2[i]     <= bus.disp_rs2[w_slot[i]];
                    r_rdy1[i]    <= w_drdy1[w_slot[i]];
                    r_rdy2[i]    <= w_drdy2[w_slot[i]];
                    r_rob[i]     <= bus.disp_rob[w_slot[i]];
                    r_payload[i] <= bus.disp_payload[w_slot[i]];
                end else if (r_valid[i]) begin
                    if (w_issue_free[i]) r_valid[i] <= 1'b0;
                    if (w_wake1[i])      r_rdy1[i]  <= 1'b1;
                    if (w_wake2[i])      r_rdy2[i]  <= 1'b1;
                end
            end
            r_older <= w_older_next;
            r_count <= w_count_next;
        end
    end
endmodule

// File: doc/rs_age_ordered.md
# rs_age_ordered

Parametrised reservation station with out-of-order wakeup, oldest-first select and multi-port issue. It sits between rename/dispatch and the functional units. It buffers up to DEPTH micro-ops that each carry two physical source tags. It snoops CDB_W result-tag broadcasts to wake operands, and issues up to ISSUE_W ready micro-ops per cycle, oldest first, under a valid/ready handshake per port.

## Interface
- DEPTH, 8, number of entries (power of two not required, ≥ DISPATCH_W)
- DISPATCH_W, 2, dispatch slots per cycle
- ISSUE_W, 2, issue ports per cycle
- CDB_W, 2, wakeup broadcast ports per cycle
- PREG_W, 6, physical register tag width
- ROB_W, 3, ROB index width
- PAYLOAD_W, 32, opaque op payload (opcode, imm, fu select) carried unchanged
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all entries (branch mispredict)
- disp_valid  in  DISPATCH_W  per-slot dispatch request; slots are contiguous from slot 0
- disp_rs1, disp_rs2  in  DISPATCH_W×PREG_W  source tags
- disp_rs1_rdy, disp_rs2_rdy  in  DISPATCH_W  operand already available at rename
- disp_rob  in  DISPATCH_W×ROB_W  ROB index
- disp_payload  in  DISPATCH_W×PAYLOAD_W  payload
- disp_ready  out  1  all DISPATCH_W slots may be accepted this cycle
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W×PREG_W  produced physical tag
- iss_valid  out  ISSUE_W  issue port holds a selected entry
- iss_ready  in  ISSUE_W  FU accepts port this cycle
- iss_rs1, iss_rs2, iss_rob, iss_payload  out  per port  fields of selected entry
- count  out  $clog2(DEPTH+1)  occupied entries (registered)
- full  out  1  count > DEPTH − DISPATCH_W

## Operation
- Entry state: valid, rs1/rs2 tag, rs1_rdy, rs2_rdy, rob, payload; age matrix older[i][j] (1 = entry i older than j).
- Dispatch: disp_ready = ~full (from registered count). Slot k is written when disp_valid[k] && disp_ready. Slots go to the lowest-index free entries in slot order. Dispatch is all-or-nothing per cycle: no partial acceptance.
- Age: on allocating entry e, set older[j][e]=1 for every already-valid j and for entries allocated from lower-numbered slots in the same cycle; clear older[e][*].
- Tag 0 is the architectural x0 tag: treated as ready at dispatch regardless of disp_rsN_rdy.
- Wakeup: for each valid entry and operand, set rdy when any cdb_valid[c] && cdb_tag[c]==tag. Dispatched operands are also compared against same-cycle CDB (dispatch bypass), so a producer broadcasting in the dispatch cycle is never missed.
- Eligible = valid && rs1_rdy && rs2_rdy (registered bits only).
- Select, combinational from registered state: port 0 gets the oldest eligible entry; port p gets the oldest eligible entry not chosen by ports < p. iss_valid[p]=0 if none remain. Output fields are driven straight from the selected entry.
- Issue: entry on port p is freed when iss_valid[p] && iss_ready[p]. If iss_ready[p]=0, that entry stays and competes again next cycle. Selection may change if an older entry becomes eligible.
- count_next = count + accepted dispatches − issue handshakes; never exceeds DEPTH, never underflows.
- Flush: clears all valid bits and sets count=0. It overrides dispatch and issue in that cycle. iss_valid remains combinational, so the FU must ignore handshakes in the flush cycle.
- Reset: as flush; also clears the age matrix.

## Timing
- Reset values: count=0, full=0 (DEPTH ≥ DISPATCH_W), disp_ready=1, iss_valid=0.
- Dispatch-to-issue: with operands ready, iss_valid asserts the cycle after dispatch (1-cycle minimum).
- Wakeup-to-issue: CDB in cycle t sets rdy at edge t+1; issue is possible in cycle t+1. There is no same-cycle CDB→issue bypass.
- Freed entries and count decrease are visible the cycle after the handshake. disp_ready is therefore conservative by one cycle.
- Simultaneous dispatch + issue + wakeup in one cycle are all applied; count reflects the net change.
- Two CDB ports carrying the same tag: idempotent.

## Test plan
- Reset then idle: count=0, disp_ready=1, iss_valid=00. Dispatch 2 ops with all rdy=1 → next cycle iss_valid=11; port 0 = slot-0 op, port 1 = slot-1 op.
- Fill: dispatch 4 cycles of 2 non-ready ops (DEPTH=8) → count 2,4,6,8; full and ~disp_ready from count=8. Further disp_valid is ignored and count holds at 8.
- Wakeup order: entries A (older) and B both waiting on tag 5. cdb_tag=5 valid in cycle t → at t+1 port 0=A, port 1=B. Waiting on different tags, waking only B's tag → port 0=B alone.
- Dispatch bypass: dispatch op with rs1=7, rs1_rdy=0 while cdb_tag=7 valid → op issues next cycle.
- Backpressure: hold iss_ready=00 for 3 cycles with 2 eligible entries → same entries and fields are held on the ports, count unchanged. Raise iss_ready=01 → only port 0 entry is freed; count −1.
- Flush mid-fill with count=5 and concurrent dispatch → next cycle count=0, iss_valid=00, the dispatched ops are discarded, disp_ready=1.
